ring_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one resource between `N` requesters, using a one-hot rotating priority pointer in the same form as the team's ring counter. It sits between requester blocks and a shared datapath resource such as a bus, register port or counter bank. Grants are registered, and a grant can be held across cycles. A hold-time limit forces preemption so that no requester can starve the others.

---
 rtl/ring_pkg.sv | 34 +++
 rtl/ring_ptr.sv | 39 +++
 rtl/ring_rr_arbiter.sv | 128 ++++++++++++
 tb/tb_ring_rr_arbiter.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/ring_pkg.sv
// Shared definitions for the ring-pointer round-robin arbiter.
//   rotl1      : one-hot rotate-left-by-1 with wrap at bit n-1
//   onehot2idx : binary index of the set bit of a one-hot vector (0 for zero)
//   arb_state_t: arbiter FSM states
package ring_pkg;

  // Widest ring the helper functions handle; callers zero-extend into this.
  localparam int unsigned MaxN = 32;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  function automatic logic [MaxN-1:0] rotl1(logic [MaxN-1:0] v, int unsigned n);
    logic [MaxN-1:0] r;
    r = '0;
    for (int unsigned i = 1; i < MaxN; i++) begin
      if (i < n) r[i] = v[i-1];
    end
    r[0] = v[n-1];
    return r;
  endfunction

  function automatic int unsigned onehot2idx(logic [MaxN-1:0] v);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < MaxN; i++) begin
      if (v[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/ring_ptr.sv
// One-hot ring pointer with load and advance enables.
//   clk_i      : clock, rising edge
//   clr_i      : synchronous active-high clear, pointer returns to bit 0
//   adv_i      : rotate pointer left by one position
//   load_i     : load load_val_i (wins over adv_i)
//   load_val_i : one-hot value to load
//   ptr_o      : current one-hot pointer
module ring_ptr
  import ring_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic         clk_i,
  input  logic         clr_i,
  input  logic         adv_i,
  input  logic         load_i,
  input  logic [N-1:0] load_val_i,
  output logic [N-1:0] ptr_o
);

  logic [N-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (load_i) begin
      ptr_d = load_val_i;
    end else if (adv_i) begin
      ptr_d = N'(rotl1(MaxN'(ptr_q), N));
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) ptr_q <= N'(1);
    else       ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter with registered grants, grant holding and hold-time preemption.
//   clk_i       : clock, rising edge
//   clr_i       : synchronous active-high clear
//   req_i       : request level per requester
//   gnt_o       : registered one-hot (or zero) grant
//   gnt_valid_o : OR of gnt_o
//   gnt_idx_o   : index of the granted requester, 0 when idle
//   preempt_o   : one-cycle pulse after a grant was revoked by timeout
module ring_rr_arbiter
  import ring_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic                 clk_i,
  input  logic                 clr_i,
  input  logic [N-1:0]         req_i,
  output logic [N-1:0]         gnt_o,
  output logic                 gnt_valid_o,
  output logic [$clog2(N)-1:0] gnt_idx_o,
  output logic                 preempt_o
);

  localparam int unsigned IdxW    = $clog2(N);
  localparam int unsigned CntW    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam int unsigned HoldMax = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;

  arb_state_t      state_q, state_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic            gnt_valid_q;
  logic [IdxW-1:0] gnt_idx_q;
  logic            preempt_q, preempt_d;
  logic [CntW-1:0] hold_cnt_q, hold_cnt_d;

  logic [N-1:0]    ptr;
  logic            ptr_load;
  logic [N-1:0]    ptr_next;
  logic [N-1:0]    pick;

  ring_ptr #(
    .N (N)
  ) u_ring_ptr (
    .clk_i      (clk_i),
    .clr_i      (clr_i),
    .adv_i      (1'b0),
    .load_i     (ptr_load),
    .load_val_i (ptr_next),
    .ptr_o      (ptr)
  );

  // Pointer moves to the position just past the current owner.
  assign ptr_next = N'(rotl1(MaxN'(gnt_q), N));

  // First set request searching upward from the pointer, wrapping at N-1.
  always_comb begin
    int unsigned base;
    int unsigned j;
    logic        found;
    pick  = '0;
    found = 1'b0;
    j     = 0;
    base  = onehot2idx(MaxN'(ptr));
    for (int unsigned k = 0; k < N; k++) begin
      j = (base + k) % N;
      if (!found && req_i[j]) begin
        pick[j] = 1'b1;
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    hold_cnt_d = hold_cnt_q;
    preempt_d  = 1'b0;
    ptr_load   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req_i) begin
          gnt_d      = pick;
          hold_cnt_d = '0;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (!(|(req_i & gnt_q))) begin
          // Release wins over a coincident timeout.
          gnt_d    = '0;
          ptr_load = 1'b1;
          state_d  = IDLE;
        end else if ((MAX_HOLD != 0) && (hold_cnt_q == CntW'(HoldMax))) begin
          gnt_d     = '0;
          ptr_load  = 1'b1;
          preempt_d = 1'b1;
          state_d   = IDLE;
        end else if ((MAX_HOLD != 0) && (hold_cnt_q != CntW'(HoldMax))) begin
          hold_cnt_d = hold_cnt_q + CntW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_idx_q   <= '0;
      preempt_q   <= 1'b0;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= |gnt_d;
      gnt_idx_q   <= IdxW'(onehot2idx(MaxN'(gnt_d)));
      preempt_q   <= preempt_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign gnt_valid_o = gnt_valid_q;
  assign gnt_idx_o   = gnt_idx_q;
  assign preempt_o   = preempt_q;

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Bench for ring_rr_arbiter: directed scenarios plus randomized traffic, every cycle
// compared against a behavioural model that tracks owner, priority index and grant length.
module tb_ring_rr_arbiter;

  localparam int unsigned N        = 4;
  localparam int unsigned MAX_HOLD = 8;

  logic         clk;
  logic         clr;
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic         gnt_valid;
  logic [1:0]   gnt_idx;
  logic         preempt;

  int n_checks = 0;
  int n_fails  = 0;

  // Model state: owner (-1 = none), priority start index, cycles the grant has been high.
  int   m_owner = -1;
  int   m_ptr   = 0;
  int   m_held  = 0;
  logic m_preempt = 1'b0;

  ring_rr_arbiter #(
    .N        (N),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk_i       (clk),
    .clr_i       (clr),
    .req_i       (req),
    .gnt_o       (gnt),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx),
    .preempt_o   (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_update(input logic [N-1:0] r, input logic c);
    m_preempt = 1'b0;
    if (c) begin
      m_owner = -1;
      m_ptr   = 0;
      m_held  = 0;
    end else if (m_owner < 0) begin
      if (r != 0) begin
        for (int k = 0; k < N; k++) begin
          if (m_owner < 0 && r[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
        end
        m_held = 1;
      end
    end else if (!r[m_owner]) begin
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
    end else if (MAX_HOLD != 0 && m_held == MAX_HOLD) begin
      m_ptr     = (m_owner + 1) % N;
      m_owner   = -1;
      m_preempt = 1'b1;
    end else begin
      m_held++;
    end
  endtask

  task automatic compare_model();
    logic [N-1:0] eg;
    eg = (m_owner < 0) ? '0 : N'(1 << m_owner);
    check("gnt", 32'(gnt), 32'(eg));
    check("gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
    check("gnt_idx", 32'(gnt_idx), (m_owner < 0) ? 32'd0 : 32'(m_owner));
    check("preempt", 32'(preempt), 32'(m_preempt));
  endtask

  // Drive inputs, take one edge, advance the model and compare just after the edge.
  task automatic step(input logic [N-1:0] r, input logic c);
    req = r;
    clr = c;
    @(posedge clk);
    model_update(r, c);
    #1;
    compare_model();
  endtask

  initial begin
    logic [N-1:0] r;
    req = '0;
    clr = 1'b1;

    // Reset with all requests pending: nothing granted.
    for (int i = 0; i < 3; i++) begin
      step(4'b1111, 1'b1);
      check("rst_gnt", 32'(gnt), 32'h0);
      check("rst_preempt", 32'(preempt), 32'h0);
    end
    step(4'b1111, 1'b0);
    check("first_gnt", 32'(gnt), 32'h1);

    // Rotation: each owner holds two cycles, then drops for one cycle.
    for (int i = 1; i <= 4; i++) begin
      step(4'b1111, 1'b0);
      r = 4'b1111 & ~gnt;
      step(r, 1'b0);
      check("rot_bubble", 32'(gnt), 32'h0);
      step(4'b1111, 1'b0);
      check("rot_idx", 32'(gnt_idx), 32'(i % 4));
    end

    // Wrap-around: owner 2 releases so the search starts at bit 3.
    step(4'b1111, 1'b0);
    step(4'b1110, 1'b0);
    step(4'b0100, 1'b0);
    check("wrap_own2", 32'(gnt), 32'h4);
    step(4'b0000, 1'b0);
    step(4'b0101, 1'b0);
    check("wrap_gnt", 32'(gnt), 32'h1);
    check("wrap_idx", 32'(gnt_idx), 32'h0);

    // Timeout: exactly MAX_HOLD cycles of grant, then a preempt bubble, then the next one.
    step(4'b0000, 1'b1);
    for (int i = 0; i < MAX_HOLD; i++) begin
      step(4'b0011, 1'b0);
      check("to_hold", 32'(gnt), 32'h1);
    end
    step(4'b0011, 1'b0);
    check("to_gnt", 32'(gnt), 32'h0);
    check("to_preempt", 32'(preempt), 32'h1);
    step(4'b0011, 1'b0);
    check("to_next", 32'(gnt), 32'h2);
    check("to_pulse", 32'(preempt), 32'h0);

    // Release coinciding with the timeout edge counts as a release.
    step(4'b0000, 1'b1);
    for (int i = 0; i < MAX_HOLD; i++) step(4'b0011, 1'b0);
    step(4'b0010, 1'b0);
    check("tie_gnt", 32'(gnt), 32'h0);
    check("tie_preempt", 32'(preempt), 32'h0);

    // Clear mid-grant returns the pointer to bit 0.
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b0);
    step(4'b0001, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b0100, 1'b0);
    step(4'b1100, 1'b0);
    check("clr_pre", 32'(gnt), 32'h4);
    step(4'b1100, 1'b1);
    check("clr_gnt", 32'(gnt), 32'h0);
    step(4'b1100, 1'b0);
    check("clr_next", 32'(gnt), 32'h4);

    // Randomized traffic: sticky request bits with occasional toggles and rare clears.
    r = '0;
    for (int i = 0; i < 2000; i++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
      end
      step(r, ($urandom_range(0, 99) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fails);
    $finish;
  end

endmodule
